// File: rtl/aes_cim_round_scheduler.sv
// AES-128 round sequencer for the CIM array: bit-serial AddRoundKey,
// S-box lookup through the array decoder, local ShiftRows/MixColumns.
module aes_cim_round_scheduler #(
    parameter int   LOOKUP_LAT = 1,
    parameter logic SBOX_BANK  = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [127:0] DIN,
    input  logic [127:0] RIO_BUS,
    output logic [15:0]  IN,
    output logic [47:0]  DEMUX_BUS,
    output logic [95:0]  RWL_BUS,
    output logic [1:0]   ARR_MODE,
    output logic [3:0]   ROUND,
    output logic         BSY,
    output logic         DVLD,
    input  logic         DACK,
    output logic [127:0] DOUT
);

    typedef enum logic [2:0] {
        IDLE, ARK, SUB_ISSUE, SUB_WAIT, LIN, DONE
    } fsm_t;

    localparam logic [2:0] WAIT_INIT = 3'(LOOKUP_LAT - 1);

    fsm_t         fsm;
    logic [127:0] data;
    logic [2:0]   bit_cnt;
    logic [2:0]   wait_cnt;
    logic [2:0]   next_k;
    logic [127:0] ark_next;
    logic [127:0] sr_out;
    logic [127:0] lin_out;
    logic [47:0]  sub_demux;
    logic [95:0]  sub_rwl;

    function automatic logic [15:0] bit_slice(input logic [127:0] x, input int b);
        logic [15:0] f;
        for (int j = 0; j < 16; j++) begin
            f[j] = x[120 - 8 * j + b];
        end
        return f;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] y;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127 - 8 * (r + 4 * c) -: 8] = x[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127 - 32 * c -: 8];
            a1 = x[119 - 32 * c -: 8];
            a2 = x[111 - 32 * c -: 8];
            a3 = x[103 - 32 * c -: 8];
            y[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            y[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            y[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            y[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return y;
    endfunction

    // Each ARK cycle shifts the array's key-XORed bit into the byte LSB.
    always_comb begin
        ark_next  = '0;
        sub_demux = '0;
        sub_rwl   = '0;
        for (int j = 0; j < 16; j++) begin
            ark_next[127 - 8 * j -: 8] = {data[126 - 8 * j -: 7], RIO_BUS[120 - 8 * j]};
        end
        for (int j = 0; j < 16; j++) begin
            sub_demux[47 - 3 * j -: 3] = {SBOX_BANK, ark_next[127 - 8 * j -: 2]};
            sub_rwl[95 - 6 * j -: 6]   = ark_next[125 - 8 * j -: 6];
        end
    end

    assign next_k  = bit_cnt + 3'd1;
    assign sr_out  = shift_rows(data);
    assign lin_out = (ROUND == 4'd10) ? sr_out : mix_columns(sr_out);

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm       <= IDLE;
            data      <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            IN        <= '0;
            DEMUX_BUS <= '0;
            RWL_BUS   <= '0;
            ARR_MODE  <= 2'b00;
            ROUND     <= '0;
            BSY       <= 1'b0;
            DVLD      <= 1'b0;
            DOUT      <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (START) begin
                        data      <= DIN;
                        ROUND     <= '0;
                        BSY       <= 1'b1;
                        bit_cnt   <= '0;
                        IN        <= bit_slice(DIN, 7);
                        DEMUX_BUS <= '0;
                        RWL_BUS   <= '0;
                        ARR_MODE  <= 2'b01;
                        fsm       <= ARK;
                    end
                end
                ARK: begin
                    data    <= ark_next;
                    bit_cnt <= next_k;
                    if (bit_cnt == 3'd7) begin
                        IN <= '0;
                        if (ROUND == 4'd10) begin
                            ARR_MODE <= 2'b00;
                            DOUT     <= ark_next;
                            DVLD     <= 1'b1;
                            fsm      <= DONE;
                        end else begin
                            ROUND     <= ROUND + 4'd1;
                            ARR_MODE  <= 2'b10;
                            DEMUX_BUS <= sub_demux;
                            RWL_BUS   <= sub_rwl;
                            fsm       <= SUB_ISSUE;
                        end
                    end else begin
                        // after the shift, bit 6 of each byte becomes its next MSB
                        IN        <= bit_slice(data, 6);
                        DEMUX_BUS <= {16{next_k}};
                    end
                end
                SUB_ISSUE: begin
                    ARR_MODE <= 2'b00;
                    wait_cnt <= WAIT_INIT;
                    fsm      <= SUB_WAIT;
                end
                SUB_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        data <= RIO_BUS;
                        fsm  <= LIN;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                LIN: begin
                    data      <= lin_out;
                    bit_cnt   <= '0;
                    IN        <= bit_slice(lin_out, 7);
                    DEMUX_BUS <= '0;
                    RWL_BUS   <= {16{{2'b00, ROUND}}};
                    ARR_MODE  <= 2'b01;
                    fsm       <= ARK;
                end
                DONE: begin
                    if (DACK) begin
                        DVLD <= 1'b0;
                        BSY  <= 1'b0;
                        fsm  <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cim_round_scheduler.sv
// Bench for aes_cim_round_scheduler: two instances (LOOKUP_LAT 1 and 3)
// against a behavioural CIM array and a cycle-offset AES model.
module tb_aes_cim_round_scheduler;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PTX = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [127:0] SROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct packed {
        logic [1:0]   mode;
        logic [3:0]   round;
        logic [15:0]  in;
        logic [47:0]  demux;
        logic [95:0]  rwl;
        logic         bsy;
        logic         dvld;
        logic [127:0] dout;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         DACK = 1'b1;
    logic [127:0] DIN = '0;

    logic [15:0]  in_b    [2];
    logic [47:0]  demux_b [2];
    logic [95:0]  rwl_b   [2];
    logic [1:0]   mode_b  [2];
    logic [3:0]   round_b [2];
    logic         bsy_b   [2];
    logic         dvld_b  [2];
    logic [127:0] dout_b  [2];
    logic [127:0] rio_b   [2];

    logic [127:0] rk [11];
    int           cyc = 0;
    int           ntotal = 0;
    int           npass = 0;

    logic         busy       [2] = '{1'b0, 1'b0};
    int           t0         [2] = '{0, 0};
    logic [127:0] pt         [2];
    logic [3:0]   round_hold [2];
    logic [127:0] dout_hold  [2];
    logic [47:0]  dmx_hold   [2];
    logic [95:0]  rwl_hold   [2];
    int           lcnt       [2] = '{0, 0};
    logic         dvld_prev  [2] = '{1'b0, 1'b0};

    always #5 CLK = ~CLK;

    aes_cim_round_scheduler #(.LOOKUP_LAT(1), .SBOX_BANK(1'b0)) u_lat1 (
        .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .RIO_BUS(rio_b[0]),
        .IN(in_b[0]), .DEMUX_BUS(demux_b[0]), .RWL_BUS(rwl_b[0]),
        .ARR_MODE(mode_b[0]), .ROUND(round_b[0]), .BSY(bsy_b[0]),
        .DVLD(dvld_b[0]), .DACK(DACK), .DOUT(dout_b[0])
    );

    aes_cim_round_scheduler #(.LOOKUP_LAT(3), .SBOX_BANK(1'b0)) u_lat3 (
        .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .RIO_BUS(rio_b[1]),
        .IN(in_b[1]), .DEMUX_BUS(demux_b[1]), .RWL_BUS(rwl_b[1]),
        .ARR_MODE(mode_b[1]), .ROUND(round_b[1]), .BSY(bsy_b[1]),
        .DVLD(dvld_b[1]), .DACK(DACK), .DOUT(dout_b[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        row = SROW[b[7:4]];
        return row[127 - 8 * int'(b[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One textbook AES round on a 4x4 byte matrix (column-major input order).
    function automatic logic [127:0] aes_round(input logic [127:0] s, input int n);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = sb(s[127 - 8 * (r + 4 * c) -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = m[r][(c + r) % 4];
        if (n < 10) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    m[r][c] = gm2(t[r][c]) ^ gm2(t[(r + 1) % 4][c]) ^ t[(r + 1) % 4][c]
                            ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
                end
            end
        end else begin
            m = t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127 - 8 * (r + 4 * c) -: 8] = m[r][c];
        return y;
    endfunction

    function automatic logic [127:0] pre_state(input logic [127:0] p, input int r);
        logic [127:0] s;
        s = p;
        for (int n = 1; n <= r; n++) s = aes_round(s ^ rk[n - 1], n);
        return s;
    endfunction

    function automatic logic [127:0] cipher(input logic [127:0] p);
        return pre_state(p, 10) ^ rk[10];
    endfunction

    initial begin
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = gm2(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    end

    // Behavioural array: same-cycle ARK bit, S-box data valid LOOKUP_LAT cycles after issue.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rio_b[i] = {4{32'hdeadbeef}};
            for (int j = 0; j < 16; j++) begin
                if (mode_b[i] == 2'b01) begin
                    rio_b[i][127 - 8 * j -: 8] = {7'h55, in_b[i][j] ^
                        ((rwl_b[i][95 - 6 * j -: 6] > 6'd10) ? 1'b0 :
                         rk[rwl_b[i][95 - 6 * j -: 6]][127 - 8 * j - int'(demux_b[i][47 - 3 * j -: 3])])};
                end else if (lcnt[i] == lat(i)) begin
                    rio_b[i][127 - 8 * j -: 8] = demux_b[i][47 - 3 * j] ? 8'h00 :
                        sb({demux_b[i][46 - 3 * j -: 2], rwl_b[i][95 - 6 * j -: 6]});
                end
            end
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                busy[i]       <= 1'b0;
                round_hold[i] <= '0;
                dout_hold[i]  <= '0;
                dmx_hold[i]   <= '0;
                rwl_hold[i]   <= '0;
                lcnt[i]       <= 0;
            end else begin
                if (mode_b[i] == 2'b10) lcnt[i] <= 1;
                else if (lcnt[i] != 0) lcnt[i] <= (lcnt[i] >= lat(i)) ? 0 : lcnt[i] + 1;
                if (!busy[i] && START) begin
                    busy[i] <= 1'b1;
                    t0[i]   <= cyc;
                    pt[i]   <= DIN;
                end else if (busy[i] && DACK && (cyc - t0[i] >= 9 + 10 * (10 + lat(i)))) begin
                    busy[i]       <= 1'b0;
                    round_hold[i] <= 4'd10;
                    dout_hold[i]  <= cipher(pt[i]);
                    dmx_hold[i]   <= {16{3'd7}};
                    rwl_hold[i]   <= {16{6'd10}};
                end
            end
        end
    end

    function automatic exp_t expect_of(input int i);
        exp_t         e;
        int           o, p, d, m, r, k;
        logic [127:0] s;
        logic [8:0]   a;
        p = 10 + lat(i);
        d = 9 + 10 * p;
        e = '{mode: 2'b00, round: round_hold[i], in: '0, demux: dmx_hold[i], rwl: rwl_hold[i],
              bsy: busy[i], dvld: 1'b0, dout: dout_hold[i]};
        if (busy[i]) begin
            o = cyc - t0[i];
            if (o >= d) begin
                e.dvld  = 1'b1;
                e.round = 4'd10;
                e.demux = {16{3'd7}};
                e.rwl   = {16{6'd10}};
                e.dout  = cipher(pt[i]);
            end else begin
                if (o <= 8) begin
                    r = 0; m = -1; k = o - 1;
                end else begin
                    r = (o - 9) / p + 1; m = (o - 9) % p; k = m - lat(i) - 2;
                end
                e.round = 4'(r);
                if (o <= 8 || m >= lat(i) + 2) begin
                    e.mode  = 2'b01;
                    s       = pre_state(pt[i], r);
                    for (int j = 0; j < 16; j++) e.in[j] = s[127 - 8 * j - k];
                    e.demux = {16{3'(k)}};
                    e.rwl   = {16{6'(r)}};
                end else begin
                    e.mode = (m == 0) ? 2'b10 : 2'b00;
                    s      = pre_state(pt[i], r - 1) ^ rk[r - 1];
                    for (int j = 0; j < 16; j++) begin
                        a = {1'b0, s[127 - 8 * j -: 8]};
                        e.demux[47 - 3 * j -: 3] = a[8:6];
                        e.rwl[95 - 6 * j -: 6]   = a[5:0];
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] req);
        ntotal++;
        if (act === req) npass++;
        else $display("FAIL %s lat%0d cyc=%0d actual=%h required=%h", nm, lat(i), cyc, act, req);
    endtask

    task automatic chk_all(input int i, input exp_t e);
        chk("ARR_MODE", i, 128'(mode_b[i]), 128'(e.mode));
        chk("ROUND", i, 128'(round_b[i]), 128'(e.round));
        chk("IN", i, 128'(in_b[i]), 128'(e.in));
        chk("DEMUX_BUS", i, 128'(demux_b[i]), 128'(e.demux));
        chk("RWL_BUS", i, 128'(rwl_b[i]), 128'(e.rwl));
        chk("BSY_DVLD", i, 128'({bsy_b[i], dvld_b[i]}), 128'({e.bsy, e.dvld}));
        chk("DOUT", i, dout_b[i], e.dout);
    endtask

    task automatic lit_checks(input int i);
        if (busy[i] && pt[i] == PT1 && cyc - t0[i] == 1)
            chk("ark0_first_in", i, 128'(in_b[i]), 128'(16'hff00));
        if (busy[i] && pt[i] == PT1 && cyc - t0[i] == 9)
            chk("r1_issue_lane0", i, 128'({mode_b[i], round_b[i], demux_b[i][47:45], rwl_b[i][95:90]}),
                128'({2'b10, 4'd1, 9'h000}));
        if (dvld_b[i] && !dvld_prev[i]) begin
            chk("dvld_latency", i, 128'(cyc - t0[i]), (i == 0) ? 128'd119 : 128'd139);
            if (pt[i] == PT1) chk("dout_fips_c1", i, dout_b[i], CT1);
        end
    endtask

    always @(negedge CLK) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                chk_all(i, expect_of(i));
                lit_checks(i);
                dvld_prev[i] <= dvld_b[i];
            end
        end
    end

    initial begin
        while (cyc < 570) begin
            @(negedge CLK);
            RST   = (cyc < 3) || (cyc == 220);
            START = (cyc == 5) || (cyc == 55) || (cyc == 160) || (cyc == 230)
                 || (cyc == 400) || (cyc == 545);
            DACK  = !(cyc >= 400 && cyc < 545);
            if (cyc == 55) DIN = PTX;
            else if (cyc == 160 || cyc == 400 || cyc == 545) DIN = PT2;
            else DIN = PT1;
        end
        @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
